// File: rtl/mouse_pi_snap_if.sv
// rtl/mouse_pi_snap_if.sv - processor-interface register bus bundle for mouse_pi_snap
interface mouse_pi_snap_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              pi_blk_sel;
    logic [ADDR_W-1:0] pi_addr;
    logic              pi_wr_en;
    logic              pi_rd_en;
    logic [DATA_W-1:0] pi_wr_data;
    logic [DATA_W-1:0] pi_rd_data;

    modport master (
        output pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
        input  pi_rd_data
    );

    modport slave (
        input  pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
        output pi_rd_data
    );
endinterface

// File: rtl/mouse_pi_snap.sv
// rtl/mouse_pi_snap.sv - mouse subsystem register block: control, colour, sticky events, coherent snapshots
module mouse_pi_snap #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int N_EVT  = 3,
    parameter int POS_W  = 11,
    parameter int LEN_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             soft_rst,
    mouse_pi_snap_if.slave   pi,
    output logic             reg_mouse_en,
    output logic             irq,
    output logic [2:0]       cursor_contour_color,
    output logic [2:0]       cursor_inter_color,
    input  logic [POS_W-1:0] cursor_x,
    input  logic [POS_W-1:0] cursor_y,
    input  logic [POS_W-1:0] left_pos_x,
    input  logic [POS_W-1:0] bot_pos_y,
    input  logic [LEN_W-1:0] sel_length,
    input  logic [N_EVT-1:0] evt_in
);
    localparam int W2 = 2 * DATA_W;

    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(32'h00);
    localparam logic [ADDR_W-1:0] A_STATUS = ADDR_W'(32'h01);
    localparam logic [ADDR_W-1:0] A_MASK   = ADDR_W'(32'h02);
    localparam logic [ADDR_W-1:0] A_COLOR  = ADDR_W'(32'h03);
    localparam logic [ADDR_W-1:0] A_X_LO   = ADDR_W'(32'h04);
    localparam logic [ADDR_W-1:0] A_X_HI   = ADDR_W'(32'h05);
    localparam logic [ADDR_W-1:0] A_Y_LO   = ADDR_W'(32'h06);
    localparam logic [ADDR_W-1:0] A_Y_HI   = ADDR_W'(32'h07);
    localparam logic [ADDR_W-1:0] A_L_LO   = ADDR_W'(32'h08);
    localparam logic [ADDR_W-1:0] A_L_HI   = ADDR_W'(32'h09);
    localparam logic [ADDR_W-1:0] A_B_LO   = ADDR_W'(32'h0A);
    localparam logic [ADDR_W-1:0] A_B_HI   = ADDR_W'(32'h0B);
    localparam logic [ADDR_W-1:0] A_S_LO   = ADDR_W'(32'h0C);
    localparam logic [ADDR_W-1:0] A_S_HI   = ADDR_W'(32'h0D);

    localparam logic [5:0] COLOR_RST = 6'b100_111;

    logic              wr;
    logic              rd;
    logic              clr;
    logic              irq_en;
    logic              pending;
    logic [N_EVT-1:0]  evt_status;
    logic [N_EVT-1:0]  evt_mask;
    logic [N_EVT-1:0]  wdata_evt;
    logic [N_EVT-1:0]  w1c;
    logic [N_EVT-1:0]  cnt_rd;
    logic [5:0]        color;
    logic [POS_W-1:0]  shd_x;
    logic [POS_W-1:0]  shd_y;
    logic [POS_W-1:0]  shd_left;
    logic [POS_W-1:0]  shd_bot;
    logic [LEN_W-1:0]  shd_len;
    logic [DATA_W-1:0] evt_cnt [N_EVT];
    logic [DATA_W-1:0] rd_mux;
    logic [DATA_W-1:0] rd_data_q;
    logic              unused_wr_bits;

    function automatic logic [DATA_W-1:0] lo_byte(input logic [W2-1:0] v);
        return v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] hi_byte(input logic [W2-1:0] v);
        return v[W2-1:DATA_W];
    endfunction

    assign wr        = pi.pi_wr_en & pi.pi_blk_sel;
    assign rd        = pi.pi_rd_en & pi.pi_blk_sel;
    assign clr       = rst | soft_rst;
    assign wdata_evt = N_EVT'(pi.pi_wr_data);
    assign w1c       = (wr && pi.pi_addr == A_STATUS) ? wdata_evt : '0;
    assign pending   = |(evt_status & evt_mask);

    assign pi.pi_rd_data          = rd_data_q;
    assign cursor_contour_color   = color[5:3];
    assign cursor_inter_color     = color[2:0];
    assign unused_wr_bits         = ^pi.pi_wr_data;

    always_comb begin
        cnt_rd = '0;
        for (int i = 0; i < N_EVT; i++)
            cnt_rd[i] = rd && (pi.pi_addr == ADDR_W'(32'h10 + i));
    end

    // Snapshot bytes are zero-extended to two bus words before slicing.
    always_comb begin
        rd_mux = '0;
        case (pi.pi_addr)
            A_CTRL:   rd_mux = DATA_W'({irq_en, reg_mouse_en});
            A_STATUS: rd_mux = DATA_W'(evt_status);
            A_MASK:   rd_mux = DATA_W'(evt_mask);
            A_COLOR:  rd_mux = DATA_W'(color);
            A_X_LO:   rd_mux = lo_byte(W2'(cursor_x));
            A_X_HI:   rd_mux = hi_byte(W2'(shd_x));
            A_Y_LO:   rd_mux = lo_byte(W2'(shd_y));
            A_Y_HI:   rd_mux = hi_byte(W2'(shd_y));
            A_L_LO:   rd_mux = lo_byte(W2'(shd_left));
            A_L_HI:   rd_mux = hi_byte(W2'(shd_left));
            A_B_LO:   rd_mux = lo_byte(W2'(shd_bot));
            A_B_HI:   rd_mux = hi_byte(W2'(shd_bot));
            A_S_LO:   rd_mux = lo_byte(W2'(shd_len));
            A_S_HI:   rd_mux = hi_byte(W2'(shd_len));
            default:  rd_mux = '0;
        endcase
        for (int i = 0; i < N_EVT; i++)
            if (pi.pi_addr == ADDR_W'(32'h10 + i))
                rd_mux = evt_cnt[i];
    end

    // Configuration survives soft_rst; only a full reset restores it.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en   <= 1'b0;
            evt_mask <= '1;
            color    <= COLOR_RST;
        end else if (wr) begin
            case (pi.pi_addr)
                A_CTRL:  irq_en   <= pi.pi_wr_data[1];
                A_MASK:  evt_mask <= wdata_evt;
                A_COLOR: color    <= pi.pi_wr_data[5:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            reg_mouse_en <= 1'b0;
            evt_status   <= '0;
            irq          <= 1'b0;
            shd_x        <= '0;
            shd_y        <= '0;
            shd_left     <= '0;
            shd_bot      <= '0;
            shd_len      <= '0;
            rd_data_q    <= '0;
        end else begin
            if (wr && pi.pi_addr == A_CTRL)
                reg_mouse_en <= pi.pi_wr_data[0];
            else if (pending)
                reg_mouse_en <= 1'b0;
            evt_status <= (evt_status & ~w1c) | evt_in;
            irq        <= irq_en & pending;
            if (rd && pi.pi_addr == A_X_LO) begin
                shd_x    <= cursor_x;
                shd_y    <= cursor_y;
                shd_left <= left_pos_x;
                shd_bot  <= bot_pos_y;
                shd_len  <= sel_length;
            end
            rd_data_q <= rd ? rd_mux : '0;
        end
    end

    // A read-clear racing an event leaves exactly that one event counted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_EVT; i++) begin
            if (clr)
                evt_cnt[i] <= '0;
            else if (cnt_rd[i])
                evt_cnt[i] <= DATA_W'(evt_in[i]);
            else if (evt_in[i] && evt_cnt[i] != '1)
                evt_cnt[i] <= evt_cnt[i] + DATA_W'(1);
        end
    end
endmodule

// File: doc/mouse_pi_snap.md
# mouse_pi_snap

Parametrised processor-interface register block for the mouse/cursor subsystem. It sits between the uP bus and the mouse datapath. It provides:
- control and colour registers;
- N sticky event channels with mask, W1C clear, saturating counters and an interrupt;
- coherent multi-byte snapshots of cursor and selection coordinates.

Read data is registered, with one-cycle latency.

## Interface
- ADDR_W, 5, pi_addr width; map needs 0x00–0x0D plus 0x10+N_EVT-1.
- DATA_W, 8, bus width.
- N_EVT, 3, event channels (1..16); ch0 click, ch1 restore, ch2 zoom.
- POS_W, 11, coordinate width; must satisfy POS_W ≤ 2*DATA_W.
- LEN_W, 10, selection length width; must satisfy LEN_W ≤ 2*DATA_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- soft_rst  in  1  synchronous soft clear (scope in Operation).
- pi_blk_sel  in  1  block select; gates all accesses.
- pi_addr  in  ADDR_W  register address.
- pi_wr_en  in  1  write strobe.
- pi_rd_en  in  1  read strobe.
- pi_wr_data  in  DATA_W  write data.
- pi_rd_data  out  DATA_W  registered read data.
- reg_mouse_en  out  1  mouse enable.
- irq  out  1  level interrupt.
- cursor_contour_color  out  3  cursor outline colour.
- cursor_inter_color  out  3  cursor fill colour.
- cursor_x, cursor_y  in  POS_W  live cursor position.
- left_pos_x, bot_pos_y  in  POS_W  live selection corner.
- sel_length  in  LEN_W  live selection half-length.
- evt_in  in  N_EVT  single-cycle event pulses.

## Operation
- Access qualifiers: wr = pi_wr_en & pi_blk_sel; rd = pi_rd_en & pi_blk_sel. wr and rd in the same cycle are both honoured independently.
- 0x00 CTRL (RW): bit0 mouse_en, bit1 irq_en. Other bits read 0.
- 0x01 EVT_STATUS: bit i is sticky, set by evt_in[i].
  - Writing 1 to bit i clears it.
  - If a clear and an event land on the same bit in the same cycle, set wins.
- 0x02 EVT_MASK (RW): reset value all ones over N_EVT bits.
- 0x03 COLOR (RW): [5:3] contour, [2:0] inter. Reset contour=RED (3'b100), inter=WHITE (3'b111).
- 0x04 CURSOR_X_LOW (read): returns live cursor_x[7:0] and, in the same cycle, captures all five position inputs into shadow registers.
- 0x05–0x0D (read): shadow bytes, zero-extended.
  - 0x05 X_HIGH, 0x06 Y_LOW, 0x07 Y_HIGH.
  - 0x08/0x09 left_x low/high, 0x0A/0x0B bot_y low/high.
  - 0x0C/0x0D sel_length low/high.
  - Writes are ignored.
- 0x10+i EVT_CNT[i]:
  - Increments on evt_in[i] and saturates at 2^DATA_W−1.
  - Read-to-clear. A clear and an event in the same cycle leave the counter at 1.
- pending = |(EVT_STATUS & EVT_MASK), from registered state.
- reg_mouse_en next-state priority:
  1. rst|soft_rst → 0;
  2. CTRL write → wdata[0];
  3. pending → 0;
  4. otherwise hold.
- Consequence: software must clear status before re-enabling, otherwise mouse_en drops on the following cycle.
- irq = irq_en & pending, registered.
- Unmapped addresses: reads return 0, writes have no effect.
- rst: all state goes to reset values.
- soft_rst clears mouse_en, EVT_STATUS, counters, shadows and irq. It does not clear COLOR, EVT_MASK or irq_en.
- Reset/soft_rst during a read: pi_rd_data = 0 next cycle.

## Timing
- Read: rd in cycle N → pi_rd_data valid in cycle N+1. pi_rd_data is 0 in any cycle not following an rd.
- Read side effects (snapshot capture, counter clear) take effect at the clock edge ending cycle N.
- Write: register updated at the edge ending the wr cycle; visible to a read issued in the next cycle.
- evt_in[i] in cycle N:
  - status bit and counter updated at the end of N;
  - pending true in N+1;
  - irq and reg_mouse_en=0 observed in N+2.
- Reset values: pi_rd_data=0, reg_mouse_en=0, irq=0, colours RED/WHITE, status 0, mask all ones, counters 0, shadows 0.

## Test plan
- Reset, then read 0x00/0x01/0x02/0x03 → 0x00, 0x00, 0x07, 0x27. Outputs reg_mouse_en=0, irq=0.
- Write CTRL=0x03, pulse evt_in[1] → status=0x02; irq=1 and reg_mouse_en=0 two cycles after the pulse. Write 0x02 to 0x01 → irq=0 next cycle.
- Coherent snapshot:
  - cursor_x=0x1FF, read 0x04 → 0xFF;
  - change cursor_x to 0x200, read 0x05 → 0x01 (shadow);
  - read 0x04 again, then 0x05 → 0x02.
- Pulse evt_in[0] 300 times (DATA_W=8) → read 0x10 gives 0xFF, a second read gives 0x00. A read coincident with a pulse leaves the counter at 0x01.
- Mask channel 2 (write 0x03 to 0x02), pulse evt_in[2] → status bit2=1, irq stays 0, reg_mouse_en stays 1. Assert soft_rst → status, counters and mouse_en cleared; COLOR and mask retained.
- Same-cycle W1C of bit0 and evt_in[0] → bit0 stays 1. Same-cycle write CTRL=0x01 with pending set → mouse_en=1 for one cycle, then 0.
